// File: rtl/vga_plot_arbiter_if.sv
// Pixel-source and adapter-side signal bundle for vga_plot_arbiter.
// master = pixel sources / adapter side, slave = the arbiter itself.
interface vga_plot_arbiter_if #(
  parameter int X_WIDTH      = 9,
  parameter int Y_WIDTH      = 8,
  parameter int COLOUR_WIDTH = 1
);
  logic                    arb_en;

  logic                    req0;
  logic [X_WIDTH-1:0]      x0;
  logic [Y_WIDTH-1:0]      y0;
  logic [COLOUR_WIDTH-1:0] colour0;
  logic                    ack0;

  logic                    req1;
  logic                    lock1;
  logic [X_WIDTH-1:0]      x1;
  logic [Y_WIDTH-1:0]      y1;
  logic [COLOUR_WIDTH-1:0] colour1;
  logic                    ack1;

  logic                    lock_abort;
  logic                    vga_plot;
  logic [X_WIDTH-1:0]      vga_x;
  logic [Y_WIDTH-1:0]      vga_y;
  logic [COLOUR_WIDTH-1:0] vga_colour;

  modport master (
    output arb_en,
    output req0, x0, y0, colour0,
    input  ack0,
    output req1, lock1, x1, y1, colour1,
    input  ack1,
    input  lock_abort, vga_plot, vga_x, vga_y, vga_colour
  );

  modport slave (
    input  arb_en,
    input  req0, x0, y0, colour0,
    output ack0,
    input  req1, lock1, x1, y1, colour1,
    output ack1,
    output lock_abort, vga_plot, vga_x, vga_y, vga_colour
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Two-source write-port arbiter for vga_adapter: per-pixel round-robin plus locked overlay bursts
// with timeout. Define VGA_ARB_STATS_EN to add stall/plot/abort statistics counters.
module vga_plot_arbiter #(
  parameter int X_WIDTH      = 9,
  parameter int Y_WIDTH      = 8,
  parameter int COLOUR_WIDTH = 1,
  parameter int MAX_BURST    = 64
) (
  input  logic                 clock,
  input  logic                 resetn,
`ifdef VGA_ARB_STATS_EN
  input  logic                 stats_clr,
  output logic [15:0]          stall0_cnt,
  output logic [15:0]          plot1_cnt,
  output logic [7:0]           abort_cnt,
`endif
  vga_plot_arbiter_if.slave    bus
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
  logic                    lock_abort_q, lock_abort_d;
  logic                    vga_plot_q;
  logic [X_WIDTH-1:0]      vga_x_q;
  logic [Y_WIDTH-1:0]      vga_y_q;
  logic [COLOUR_WIDTH-1:0] vga_colour_q;

  logic                    en;
  logic                    ack0_c;
  logic                    ack1_c;

  // Acks are combinational, so gate them with resetn to keep them low while reset is held.
  assign en = bus.arb_en & resetn;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    lock_abort_d = 1'b0;
    ack0_c       = 1'b0;
    ack1_c       = 1'b0;

    case (state_q)
      ARB: begin
        if (en) begin
          if (bus.req0 && (!bus.req1 || last_grant_q)) begin
            ack0_c       = 1'b1;
            last_grant_d = 1'b0;
          end else if (bus.req1) begin
            ack1_c       = 1'b1;
            last_grant_d = 1'b1;
            if (bus.lock1) begin
              state_d     = LOCK1;
              burst_cnt_d = CNT_W'(1);
            end
          end
        end
      end

      LOCK1: begin
        ack1_c      = en & bus.req1;
        burst_cnt_d = burst_cnt_q + 1'b1;
        // A release in the timeout cycle wins, so no abort is signalled then.
        if (ack1_c && !bus.lock1) begin
          state_d      = ARB;
          last_grant_d = 1'b1;
          burst_cnt_d  = '0;
        end else if (burst_cnt_q == TIMEOUT_CNT) begin
          state_d      = ARB;
          last_grant_d = 1'b1;
          burst_cnt_d  = '0;
          lock_abort_d = 1'b1;
        end
      end

      default: begin
        state_d = ARB;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      burst_cnt_q  <= '0;
      lock_abort_q <= 1'b0;
      vga_plot_q   <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      lock_abort_q <= lock_abort_d;
      vga_plot_q   <= ack0_c | ack1_c;
      if (ack0_c) begin
        vga_x_q      <= bus.x0;
        vga_y_q      <= bus.y0;
        vga_colour_q <= bus.colour0;
      end else if (ack1_c) begin
        vga_x_q      <= bus.x1;
        vga_y_q      <= bus.y1;
        vga_colour_q <= bus.colour1;
      end
    end
  end

  assign bus.ack0       = ack0_c;
  assign bus.ack1       = ack1_c;
  assign bus.lock_abort = lock_abort_q;
  assign bus.vga_plot   = vga_plot_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;

`ifdef VGA_ARB_STATS_EN
  logic [15:0] stall0_q;
  logic [15:0] plot1_q;
  logic [7:0]  abort_q;

  // Saturating counters; a clear in the same cycle as an increment leaves zero.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall0_q <= '0;
      plot1_q  <= '0;
      abort_q  <= '0;
    end else if (stats_clr) begin
      stall0_q <= '0;
      plot1_q  <= '0;
      abort_q  <= '0;
    end else begin
      if (bus.req0 && !ack0_c && (stall0_q != 16'hFFFF)) begin
        stall0_q <= stall0_q + 16'd1;
      end
      if (ack1_c && (plot1_q != 16'hFFFF)) begin
        plot1_q <= plot1_q + 16'd1;
      end
      if (lock_abort_d && (abort_q != 8'hFF)) begin
        abort_q <= abort_q + 8'd1;
      end
    end
  end

  assign stall0_cnt = stall0_q;
  assign plot1_cnt  = plot1_q;
  assign abort_cnt  = abort_q;
`endif

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: vector table for arbitration plus hand sequences
// for reset, locked bursts, release/timeout and enable gating; pixels tracked in a queue.
module tb_vga_plot_arbiter;

  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 1;
  localparam int PW = XW + YW + CW;

  typedef logic [PW-1:0] pix_t;

  typedef struct {
    logic en;
    logic r0;
    logic r1;
    logic l1;
    logic a0;
    logic a1;
  } vec_t;

  logic clk;
  logic resetn;
  int   total;
  int   bad;
  pix_t exp_q[$];
  vec_t vecs[13];

  vga_plot_arbiter_if #(.X_WIDTH(XW), .Y_WIDTH(YW), .COLOUR_WIDTH(CW)) bus ();

`ifdef VGA_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] stall0_cnt;
  logic [15:0] plot1_cnt;
  logic [7:0]  abort_cnt;
`endif

  vga_plot_arbiter #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .COLOUR_WIDTH(CW), .MAX_BURST(64)
  ) dut (
    .clock      (clk),
    .resetn     (resetn),
`ifdef VGA_ARB_STATS_EN
    .stats_clr  (stats_clr),
    .stall0_cnt (stall0_cnt),
    .plot1_cnt  (plot1_cnt),
    .abort_cnt  (abort_cnt),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_in(input logic en, input logic r0, input logic r1, input logic l1);
    bus.arb_en  = en;
    bus.req0    = r0;
    bus.req1    = r1;
    bus.lock1   = l1;
    bus.x0      = XW'($urandom);
    bus.y0      = YW'($urandom);
    bus.colour0 = CW'($urandom);
    bus.x1      = XW'($urandom);
    bus.y1      = YW'($urandom);
    bus.colour1 = CW'($urandom);
  endtask

  // One clock: check acks mid-cycle, queue the accepted pixel, check outputs after the edge.
  task automatic step(input string name, input logic e0, input logic e1, input logic eab);
    pix_t exp_pix;
    @(negedge clk);
    check({name, ".ack0"}, 32'(bus.ack0), 32'(e0));
    check({name, ".ack1"}, 32'(bus.ack1), 32'(e1));
    if (e0) exp_q.push_back({bus.x0, bus.y0, bus.colour0});
    else if (e1) exp_q.push_back({bus.x1, bus.y1, bus.colour1});
    @(posedge clk);
    #1;
    if (e0 || e1) begin
      exp_pix = exp_q.pop_front();
      check({name, ".plot"}, 32'(bus.vga_plot), 32'd1);
      check({name, ".pixel"}, 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(exp_pix));
    end else begin
      check({name, ".plot"}, 32'(bus.vga_plot), 32'd0);
    end
    check({name, ".abort"}, 32'(bus.lock_abort), 32'(eab));
    $display("step %s en=%0b r0=%0b r1=%0b l1=%0b ack0=%0b ack1=%0b plot=%0b abort=%0b",
             name, bus.arb_en, bus.req0, bus.req1, bus.lock1, e0, e1, bus.vga_plot, bus.lock_abort);
  endtask

  task automatic clear_stats();
`ifdef VGA_ARB_STATS_EN
    stats_clr = 1'b1;
`endif
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    step("clr", 1'b0, 1'b0, 1'b0);
`ifdef VGA_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
  endtask

  initial begin
    logic r1;
    total = 0;
    bad   = 0;
`ifdef VGA_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    //          en    r0    r1    l1    a0    a1
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    resetn = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst.plot", 32'(bus.vga_plot), 32'd0);
    check("rst.x", 32'(bus.vga_x), 32'd0);
    check("rst.y", 32'(bus.vga_y), 32'd0);
    check("rst.colour", 32'(bus.vga_colour), 32'd0);
    check("rst.abort", 32'(bus.lock_abort), 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      set_in(vecs[i].en, vecs[i].r0, vecs[i].r1, vecs[i].l1);
      step($sformatf("vec%0d", i), vecs[i].a0, vecs[i].a1, 1'b0);
    end

    // Single stream with fixed pixel.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b1, 1'b0, 1'b0);
      bus.x0 = 9'd5;
      bus.y0 = 8'd7;
      bus.colour0 = 1'b1;
      step($sformatf("stream%0d", i), 1'b1, 1'b0, 1'b0);
    end
    check("stream.x", 32'(bus.vga_x), 32'd5);
    check("stream.y", 32'(bus.vga_y), 32'd7);

    // Reset mid-stream clears outputs and acks at once.
    resetn = 1'b0;
    #1;
    check("midrst.ack0", 32'(bus.ack0), 32'd0);
    check("midrst.ack1", 32'(bus.ack1), 32'd0);
    check("midrst.plot", 32'(bus.vga_plot), 32'd0);
    check("midrst.x", 32'(bus.vga_x), 32'd0);
    check("midrst.y", 32'(bus.vga_y), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    step("postrst0", 1'b1, 1'b0, 1'b0);
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    step("postrst1", 1'b0, 1'b1, 1'b0);

    // Locked burst of 25 pixels with req0 held throughout.
    clear_stats();
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    step("pre_burst", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      set_in(1'b1, 1'b1, 1'b1, (i < 24) ? 1'b1 : 1'b0);
      step($sformatf("burst%0d", i), 1'b0, 1'b1, 1'b0);
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b0);
    step("burst_after", 1'b1, 1'b0, 1'b0);
`ifdef VGA_ARB_STATS_EN
    check("plot1_cnt", 32'(plot1_cnt), 32'd25);
`endif

    // Release lands in the timeout cycle: normal release, no abort; arb_en low early in the lock.
    set_in(1'b1, 1'b0, 1'b1, 1'b1);
    step("rel_c0", 1'b0, 1'b1, 1'b0);
    for (int c = 1; c < 63; c++) begin
      set_in((c < 10) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b1);
      step($sformatf("rel_c%0d", c), 1'b0, 1'b0, 1'b0);
    end
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    step("rel_c63", 1'b0, 1'b1, 1'b0);
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    step("rel_after", 1'b1, 1'b0, 1'b0);

    // Timeout: lock1 stays high, req1 on even lock cycles.
    set_in(1'b1, 1'b0, 1'b1, 1'b1);
    step("to_c0", 1'b0, 1'b1, 1'b0);
    for (int c = 1; c < 64; c++) begin
      r1 = (c % 2 == 0);
      set_in(1'b1, 1'b1, r1, 1'b1);
      step($sformatf("to_c%0d", c), 1'b0, r1, (c == 63));
    end
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    step("to_after", 1'b1, 1'b0, 1'b0);
`ifdef VGA_ARB_STATS_EN
    check("abort_cnt", 32'(abort_cnt), 32'd1);
`endif

    // Enable gating with both requests high.
    clear_stats();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b0);
      step($sformatf("gate%0d", i), 1'b0, 1'b0, 1'b0);
    end
`ifdef VGA_ARB_STATS_EN
    check("stall0_cnt", 32'(stall0_cnt), 32'd10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single write port of vga_adapter between two pixel sources.
- Requester 0 is the motion-map scanner; it streams one pixel per request.
- Requester 1 is the overlay drawer (centroid box, markers); it issues locked bursts.
- Sits between the display-side pixel generators and vga_adapter, and provides fair per-pixel round-robin, atomic overlay bursts, and a burst timeout.

Parameters:
- X_WIDTH, 9, x coordinate width.
- Y_WIDTH, 8, y coordinate width.
- COLOUR_WIDTH, 1, colour width (monochrome adapter).
- MAX_BURST, 64, maximum cycles requester 1 may hold a lock before forced release.

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  asynchronous active-low reset
- arb_en  in  1  arbiter enable; when 0 no request is accepted
- req0  in  1  scanner pixel request
- x0, y0, colour0  in  X_WIDTH/Y_WIDTH/COLOUR_WIDTH  scanner pixel
- ack0  out  1  scanner pixel accepted this cycle
- req1  in  1  overlay pixel request
- lock1  in  1  overlay holds grant after this pixel
- x1, y1, colour1  in  X_WIDTH/Y_WIDTH/COLOUR_WIDTH  overlay pixel
- ack1  out  1  overlay pixel accepted this cycle
- lock_abort  out  1  one-cycle pulse when a lock is force-released
- vga_plot  out  1  registered plot strobe to vga_adapter
- vga_x, vga_y, vga_colour  out  X_WIDTH/Y_WIDTH/COLOUR_WIDTH  registered pixel to vga_adapter

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state: state=ARB, last_grant=1 (so requester 0 wins first contention), burst_cnt=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, lock_abort=0.
- Handshake:
  - Requester holds reqN and its data stable until it sees ackN=1.
  - ackN is combinational from state, arb_en and the requests.
  - The requester advances on the cycle after ack.
- Latency: an accepted pixel appears on vga_x/vga_y/vga_colour with vga_plot=1 on the next clock edge.
  - vga_plot=0 in any cycle following no acceptance; coordinates then hold their last value.
- State ARB:
  - arb_en=0: no ack, stay.
  - Only req0: ack0.
  - Only req1: ack1.
  - Both: grant the requester != last_grant.
  - On any grant, last_grant := granted index.
  - If ack1 and lock1=1: go to LOCK1 with burst_cnt := 1.
- State LOCK1:
  - Only req1 may be acked; ack0=0 regardless of req0.
  - burst_cnt increments every cycle, including idle cycles with req1=0 or arb_en=0.
  - ack1 with lock1=0: last pixel of the burst; go to ARB, last_grant=1.
  - burst_cnt == MAX_BURST-1 at a clock edge without release: forced return to ARB, lock_abort=1 for one cycle, last_grant=1.
  - The final pixel is accepted if ack1 occurs in that cycle.
  - After a timeout, requester 1 must re-request to relock.
- Simultaneous release and timeout in the same cycle count as a normal release; lock_abort stays 0.
- burst_cnt width is clog2(MAX_BURST)+1; it never wraps.
- arb_en falling while in LOCK1 keeps the lock state and the timeout still runs.
- Reset asserted mid-burst: immediate return to reset state; no partial pixel is emitted.
- Coordinates pass through unmodified; no range checking is done (vga_adapter clips).

Optional Feature:
- Macro: VGA_ARB_STATS_EN.
- With the macro defined, the block adds these outputs:
  - stall0_cnt [15:0]: saturating count of cycles with req0=1 and ack0=0.
  - plot1_cnt [15:0]: saturating count of overlay pixels accepted.
  - abort_cnt [7:0]: saturating count of lock_abort pulses.
  - stats_clr input: synchronous clear of all three counters; clear wins over increment.
- All counters reset to 0.
- Without the macro, these ports and registers are absent and arbitration behaviour is identical.

Test Plan:
- Reset values: assert resetn=0 mid-stream -> vga_plot=0, vga_x=0, vga_y=0, ack0=ack1=0 immediately; after release, first contention goes to requester 0.
- Single stream: req0 held with x0=5,y0=7,colour0=1, arb_en=1 -> ack0=1 every cycle; next cycle vga_plot=1, vga_x=5, vga_y=7, vga_colour=1.
- Contention: req0=req1=1 constant, lock1=0 for 6 cycles -> ack sequence 0,1,0,1,0,1; vga_plot=1 for 6 consecutive cycles.
- Locked burst: req1 burst of 25 pixels (lock1=1 on the first 24, 0 on the 25th) with req0 held -> ack1 25 consecutive cycles, ack0=0 throughout, then ack0=1 on cycle 26.
- Timeout: lock1 held at 1 with req1 pulsing every other cycle, MAX_BURST=64 -> lock_abort pulses once at lock cycle 64, next contention grants requester 0; with VGA_ARB_STATS_EN, abort_cnt=1.
- Enable gating: arb_en=0 for 10 cycles with both requests high -> no ack, vga_plot=0; stall0_cnt=10 with the stats macro.
